sd_cmd_framer: RTL and testbench
================================

Name: sd_cmd_framer

Overview:
- Command-level front end that sits directly upstream of the microSD SPI byte engine and drives its byte-write strobe/data interface.
- Accepts one SD command (index + 32-bit argument), frames it into the 6-byte SPI-mode command token, then polls with 0xFF bytes for the R1 response.
- Returns the R1 byte or a timeout to the init/read controller above.
- Owns chip-select framing, including 8 trailing clocks after each command.

Parameters:
- NCR_MAX, 8, max 0xFF poll bytes sent while waiting for R1 (1..255).
- FILL_BYTE, 8'hFF, byte sent during polling and the trailer.

Ports:
- CLK50  in  1  system clock, 50 MHz, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CMD_STB  in  1  one-cycle command request; honoured only while CMD_BUSY=0.
- CMD_IDX  in  6  command index, sampled on accepted CMD_STB.
- CMD_ARG  in  32  command argument, sampled on accepted CMD_STB.
- CMD_BUSY  out  1  high from the cycle after acceptance until RESP_VALID.
- RESP_VALID  out  1  one-cycle pulse; RESP_R1 and RESP_TIMEOUT are valid with it.
- RESP_R1  out  8  received R1 byte (0xFF on timeout); held until the next RESP_VALID.
- RESP_TIMEOUT  out  1  set with RESP_VALID when no R1 arrived within NCR_MAX bytes.
- SPI_W_STB  out  1  one-cycle byte-transfer request to the SPI engine.
- SPI_W_DATA  out  8  byte to shift out; valid with SPI_W_STB.
- SPI_DONE  in  1  one-cycle pulse from the SPI engine when a byte completes.
- SPI_R_DATA  in  8  byte shifted in on MISO; valid with SPI_DONE.
- SPI_CS_N  out  1  chip select to the card, active low.

Behaviour:
- Reset (async, any state): state=IDLE; SPI_CS_N=1, SPI_W_STB=0, SPI_W_DATA=0, CMD_BUSY=0, RESP_VALID=0, RESP_R1=8'hFF, RESP_TIMEOUT=0; counters cleared.
- Mid-operation reset abandons the transfer. No trailer is sent.

FSM states: IDLE, ISSUE, WAIT, POLL_ISSUE, POLL_WAIT, TRAIL_ISSUE, TRAIL_WAIT, REPORT.
- IDLE:
  - CMD_STB=1 latches IDX/ARG, drives SPI_CS_N=0, sets byte_cnt=0, goes to ISSUE.
  - SPI_DONE is ignored here.
- ISSUE: pulse SPI_W_STB for one cycle with token byte[byte_cnt], then go to WAIT.
  - byte0={2'b01,IDX}; bytes1-4 = ARG, MSB first; byte5={CRC7,1'b1}.
- WAIT: on SPI_DONE, if byte_cnt<5 then increment and go to ISSUE, else set poll_cnt=0 and go to POLL_ISSUE.
  - Next strobe is issued exactly one cycle after SPI_DONE.
- POLL_ISSUE: strobe FILL_BYTE, then go to POLL_WAIT.
- POLL_WAIT: on SPI_DONE, poll_cnt++.
  - SPI_R_DATA[7]=0: capture it as R1, timeout=0, go to TRAIL_ISSUE.
  - Else if poll_cnt==NCR_MAX: R1=0xFF, timeout=1, go to TRAIL_ISSUE.
  - Else go to POLL_ISSUE.
- TRAIL_ISSUE/TRAIL_WAIT: send one FILL_BYTE with CS still low; on SPI_DONE drive SPI_CS_N=1 and go to REPORT.
- REPORT: RESP_VALID=1 for one cycle, CMD_BUSY=0, then IDLE.
  - A CMD_STB in the REPORT cycle is ignored.
  - A CMD_STB in the following IDLE cycle is accepted.
- CMD_STB while busy is dropped (no queue).
- SPI_DONE arriving in ISSUE-type states is ignored; the engine never produces it there.
- Received bytes during command bytes 0-5 are discarded.

Optional Feature:
- SD_CMD_CRC7_EN defined:
  - CRC7 computed serially over bytes 0-4, poly x^7+x^3+1, init 0.
  - Computed in ISSUE/WAIT alongside transmission, ready before byte5.
- Not defined:
  - byte5 is constant 8'h95, valid for CMD0 only.
  - Only CMD0 and CRC-off SPI-mode commands are usable.

Decomposition:
- Package sd_pkg holds:
  - state encoding localparams;
  - SD_START_BITS=2'b01, SD_FILL=8'hFF, SD_CMD0_CRC=8'h95;
  - command index constants CMD0, CMD8, CMD17, CMD55, ACMD41.
- One natural sub-module: sd_crc7, a bit-serial CRC7 with clear/enable/data-in ports, instantiated only under SD_CMD_CRC7_EN.

Test Plan:
- CMD0, ARG=0, SPI model returns 0xFF then 0x01 → SPI_W_DATA sequence 40 00 00 00 00 95 FF FF FF.
  - RESP_R1=0x01, TIMEOUT=0; CS_N low from acceptance to trailer done.
- CMD8, ARG=0x000001AA, CRC7_EN defined → bytes 48 00 00 01 AA 87.
  - Model returns 0x01 on the 1st poll; RESP_VALID exactly once.
- Model always returns 0xFF, NCR_MAX=8 → exactly 8 poll bytes plus 1 trailer.
  - RESP_TIMEOUT=1, RESP_R1=0xFF.
- CMD_STB pulsed again during byte 2 → ignored.
  - Token unchanged; a single RESP_VALID.
  - Next CMD_STB one cycle after RESP_VALID is accepted.
- RST_N asserted during POLL_WAIT → asynchronously SPI_CS_N=1, CMD_BUSY=0, SPI_W_STB=0.
  - A new CMD0 after release completes normally.
- Back-to-back handshake check: SPI_W_STB occurs exactly 1 cycle after each SPI_DONE.
  - SPI_W_STB is never asserted while a byte is outstanding.

Source files
------------

// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD SPI-mode command framer:
//   - FSM state encoding and enum
//   - SPI-mode token constants (start bits, fill byte, CMD0 CRC byte)
//   - common command index constants
//   - helpers: one CRC7 bit step and the command token byte selector
// Optional feature macro used by the framer: SD_CMD_CRC7_EN
// ---------------------------------------------------------------------------
package sd_pkg;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ISSUE       = 3'd1;
    localparam logic [2:0] S_WAIT        = 3'd2;
    localparam logic [2:0] S_POLL_ISSUE  = 3'd3;
    localparam logic [2:0] S_POLL_WAIT   = 3'd4;
    localparam logic [2:0] S_TRAIL_ISSUE = 3'd5;
    localparam logic [2:0] S_TRAIL_WAIT  = 3'd6;
    localparam logic [2:0] S_REPORT      = 3'd7;

    typedef enum logic [2:0] {
        IDLE        = S_IDLE,
        ISSUE       = S_ISSUE,
        WAIT        = S_WAIT,
        POLL_ISSUE  = S_POLL_ISSUE,
        POLL_WAIT   = S_POLL_WAIT,
        TRAIL_ISSUE = S_TRAIL_ISSUE,
        TRAIL_WAIT  = S_TRAIL_WAIT,
        REPORT      = S_REPORT
    } sd_state_t;

    localparam logic [1:0] SD_START_BITS = 2'b01;
    localparam logic [7:0] SD_FILL       = 8'hFF;
    localparam logic [7:0] SD_CMD0_CRC   = 8'h95;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    // One bit of the x^7+x^3+1 CRC, message bits fed MSB first.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // Byte n of the 6-byte command token: start+index, argument MSB first, CRC byte.
    function automatic logic [7:0] token_byte(input logic [5:0]  idx,
                                              input logic [31:0] arg,
                                              input logic [7:0]  crc_byte,
                                              input logic [2:0]  n);
        case (n)
            3'd0:    return {SD_START_BITS, idx};
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            default: return crc_byte;
        endcase
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// ---------------------------------------------------------------------------
// sd_crc7
// Bit-serial CRC7 (x^7+x^3+1, init 0) for SD command tokens.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       restart the CRC at zero (wins over enable)
//   enable      absorb din this cycle
//   din         next message bit, MSB first
//   crc         current 7-bit remainder
// ---------------------------------------------------------------------------
import sd_pkg::*;

module sd_crc7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       din,
    output logic [6:0] crc
);

    // Remainder register; clear has priority so a new command always starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'd0;
        end else if (clear) begin
            crc <= 7'd0;
        end else if (enable) begin
            crc <= crc7_next(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_framer.sv
// ---------------------------------------------------------------------------
// sd_cmd_framer
// Frames one SD command (index + argument) into the 6-byte SPI-mode token,
// polls with fill bytes for the R1 response, sends one trailing fill byte
// with CS still low, then reports R1 or a timeout.
// Optional feature macro: SD_CMD_CRC7_EN
//   defined   : CRC7 computed over bytes 0-4 while they are sent
//   undefined : byte 5 is the fixed CMD0 CRC byte 8'h95
// Ports:
//   CLK50, RST_N               clock, asynchronous active-low reset
//   CMD_STB, CMD_IDX, CMD_ARG  command request (taken only when idle)
//   CMD_BUSY                   command in flight
//   RESP_VALID/R1/TIMEOUT      one-cycle result report, R1/TIMEOUT held
//   SPI_W_STB, SPI_W_DATA      byte-transfer request to the SPI engine
//   SPI_DONE, SPI_R_DATA       byte completion and received byte
//   SPI_CS_N                   card chip select, active low
// ---------------------------------------------------------------------------
import sd_pkg::*;

module sd_cmd_framer #(
    parameter int         NCR_MAX   = 8,
    parameter logic [7:0] FILL_BYTE = SD_FILL
) (
    input  logic        CLK50,
    input  logic        RST_N,
    input  logic        CMD_STB,
    input  logic [5:0]  CMD_IDX,
    input  logic [31:0] CMD_ARG,
    output logic        CMD_BUSY,
    output logic        RESP_VALID,
    output logic [7:0]  RESP_R1,
    output logic        RESP_TIMEOUT,
    output logic        SPI_W_STB,
    output logic [7:0]  SPI_W_DATA,
    input  logic        SPI_DONE,
    input  logic [7:0]  SPI_R_DATA,
    output logic        SPI_CS_N
);

    localparam logic [7:0] NCR_LIMIT = NCR_MAX[7:0];

    sd_state_t   state;
    logic [2:0]  byte_cnt;
    logic [7:0]  poll_cnt;
    logic [7:0]  poll_next;
    logic [5:0]  cmd_idx_q;
    logic [31:0] cmd_arg_q;
    logic [7:0]  r1_cap;
    logic        timeout_cap;
    logic [7:0]  crc_byte;
    logic        accept;

    assign accept    = (state == IDLE) && CMD_STB;
    assign poll_next = poll_cnt + 8'd1;

`ifdef SD_CMD_CRC7_EN
    logic [39:0] crc_shift;
    logic [5:0]  crc_bits;
    logic        crc_en;
    logic [6:0]  crc_val;

    assign crc_en   = (crc_bits != 6'd0);
    assign crc_byte = {crc_val, 1'b1};

    // Feed bytes 0-4 into the CRC one bit per clock starting right after
    // acceptance. 40 clocks is shorter than five 8-bit SPI transfers, so the
    // remainder is settled before byte 5 is selected.
    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            crc_shift <= 40'd0;
            crc_bits  <= 6'd0;
        end else if (accept) begin
            crc_shift <= {SD_START_BITS, CMD_IDX, CMD_ARG};
            crc_bits  <= 6'd40;
        end else if (crc_en) begin
            crc_shift <= {crc_shift[38:0], 1'b0};
            crc_bits  <= crc_bits - 6'd1;
        end
    end

    sd_crc7 u_crc7 (
        .clk    (CLK50),
        .rst_n  (RST_N),
        .clear  (accept),
        .enable (crc_en),
        .din    (crc_shift[39]),
        .crc    (crc_val)
    );
`else
    assign crc_byte = SD_CMD0_CRC;
`endif

    // Main sequencer. Every strobe is raised on the transition into an
    // *_ISSUE state, so it appears exactly one cycle after the SPI_DONE that
    // finished the previous byte, and each *_ISSUE state just drops it again.
    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            byte_cnt     <= 3'd0;
            poll_cnt     <= 8'd0;
            cmd_idx_q    <= 6'd0;
            cmd_arg_q    <= 32'd0;
            r1_cap       <= 8'hFF;
            timeout_cap  <= 1'b0;
            SPI_CS_N     <= 1'b1;
            SPI_W_STB    <= 1'b0;
            SPI_W_DATA   <= 8'h00;
            CMD_BUSY     <= 1'b0;
            RESP_VALID   <= 1'b0;
            RESP_R1      <= 8'hFF;
            RESP_TIMEOUT <= 1'b0;
        end else begin
            SPI_W_STB  <= 1'b0;
            RESP_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_STB) begin
                        cmd_idx_q  <= CMD_IDX;
                        cmd_arg_q  <= CMD_ARG;
                        SPI_CS_N   <= 1'b0;
                        CMD_BUSY   <= 1'b1;
                        byte_cnt   <= 3'd0;
                        SPI_W_STB  <= 1'b1;
                        SPI_W_DATA <= {SD_START_BITS, CMD_IDX};
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (SPI_DONE) begin
                        SPI_W_STB <= 1'b1;
                        if (byte_cnt < 3'd5) begin
                            byte_cnt   <= byte_cnt + 3'd1;
                            SPI_W_DATA <= token_byte(cmd_idx_q, cmd_arg_q, crc_byte, byte_cnt + 3'd1);
                            state      <= ISSUE;
                        end else begin
                            poll_cnt   <= 8'd0;
                            SPI_W_DATA <= FILL_BYTE;
                            state      <= POLL_ISSUE;
                        end
                    end
                end
                POLL_ISSUE: state <= POLL_WAIT;
                POLL_WAIT: begin
                    if (SPI_DONE) begin
                        poll_cnt   <= poll_next;
                        SPI_W_STB  <= 1'b1;
                        SPI_W_DATA <= FILL_BYTE;
                        if (!SPI_R_DATA[7]) begin
                            r1_cap      <= SPI_R_DATA;
                            timeout_cap <= 1'b0;
                            state       <= TRAIL_ISSUE;
                        end else if (poll_next == NCR_LIMIT) begin
                            r1_cap      <= 8'hFF;
                            timeout_cap <= 1'b1;
                            state       <= TRAIL_ISSUE;
                        end else begin
                            state <= POLL_ISSUE;
                        end
                    end
                end
                TRAIL_ISSUE: state <= TRAIL_WAIT;
                TRAIL_WAIT: begin
                    if (SPI_DONE) begin
                        SPI_CS_N     <= 1'b1;
                        CMD_BUSY     <= 1'b0;
                        RESP_VALID   <= 1'b1;
                        RESP_R1      <= r1_cap;
                        RESP_TIMEOUT <= timeout_cap;
                        state        <= REPORT;
                    end
                end
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_framer
// Scoreboard bench for sd_cmd_framer with a behavioural SPI engine model.
// Expected token bytes and responses are queued as each command is issued;
// independent monitors pop and compare whenever the DUT strobes a byte or
// reports a response.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

import sd_pkg::*;

module tb_sd_cmd_framer;

    localparam int LAT = 10;

    logic        CLK50 = 1'b0;
    logic        RST_N = 1'b0;
    logic        CMD_STB = 1'b0;
    logic [5:0]  CMD_IDX = 6'd0;
    logic [31:0] CMD_ARG = 32'd0;
    logic        CMD_BUSY;
    logic        RESP_VALID;
    logic [7:0]  RESP_R1;
    logic        RESP_TIMEOUT;
    logic        SPI_W_STB;
    logic [7:0]  SPI_W_DATA;
    logic        SPI_DONE = 1'b0;
    logic [7:0]  SPI_R_DATA = 8'h00;
    logic        SPI_CS_N;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_bytes[$];
    logic [8:0] exp_resp[$];
    logic [7:0] reply_q[$];

    int cyc = 0;
    int done_cyc = -10;
    int countdown = 0;
    int tx_idx = 0;
    int cur_idx = 0;
    bit outstanding = 0;
    bit first_byte = 1;

`ifdef SD_CMD_CRC7_EN
    localparam logic [7:0] CMD8_CRC = 8'h87;
    localparam bit CRC_DC = 1'b1;
`else
    localparam logic [7:0] CMD8_CRC = 8'h95;
    localparam bit CRC_DC = 1'b0;
`endif

    sd_cmd_framer #(.NCR_MAX(8), .FILL_BYTE(8'hFF)) dut (
        .CLK50        (CLK50),
        .RST_N        (RST_N),
        .CMD_STB      (CMD_STB),
        .CMD_IDX      (CMD_IDX),
        .CMD_ARG      (CMD_ARG),
        .CMD_BUSY     (CMD_BUSY),
        .RESP_VALID   (RESP_VALID),
        .RESP_R1      (RESP_R1),
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .SPI_W_STB    (SPI_W_STB),
        .SPI_W_DATA   (SPI_W_DATA),
        .SPI_DONE     (SPI_DONE),
        .SPI_R_DATA   (SPI_R_DATA),
        .SPI_CS_N     (SPI_CS_N)
    );

    always #10 CLK50 = ~CLK50;

    // Safety net in case something hangs outside the bounded waits
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // SPI engine model: each strobe completes LAT cycles later with a one-cycle
    // SPI_DONE. Command bytes get 8'h00 back (must be discarded); poll bytes
    // take the next queued reply or 8'hFF. Also checks strobe pacing.
    always @(negedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            SPI_DONE    = 1'b0;
            countdown   = 0;
            outstanding = 0;
            tx_idx      = 0;
            first_byte  = 1;
        end else begin
            cyc = cyc + 1;
            if (SPI_DONE) SPI_DONE = 1'b0;
            if (SPI_CS_N) begin
                tx_idx     = 0;
                first_byte = 1;
            end
            if (SPI_W_STB) begin
                checks++;
                if (outstanding) begin
                    errors++;
                    $display("[TB] FAIL stb_overlap: strobe at cycle %0d while byte outstanding, required none", cyc);
                end
                if (!first_byte) begin
                    checks++;
                    if (cyc != done_cyc + 1) begin
                        errors++;
                        $display("[TB] FAIL stb_gap: strobe at cycle %0d, required %0d", cyc, done_cyc + 1);
                    end
                end
                first_byte  = 0;
                outstanding = 1;
                countdown   = LAT;
                cur_idx     = tx_idx;
                tx_idx      = tx_idx + 1;
            end else if (countdown > 0) begin
                countdown = countdown - 1;
                if (countdown == 0) begin
                    SPI_DONE    = 1'b1;
                    outstanding = 0;
                    done_cyc    = cyc;
                    if (cur_idx < 6)
                        SPI_R_DATA = 8'h00;
                    else if (reply_q.size() > 0)
                        SPI_R_DATA = reply_q.pop_front();
                    else
                        SPI_R_DATA = 8'hFF;
                end
            end
        end
    end

    // Byte monitor: every strobed byte is compared against the queued token
    logic [8:0] eb;
    always @(negedge CLK50) begin
        if (RST_N && SPI_W_STB) begin
            checks++;
            if (exp_bytes.size() == 0) begin
                errors++;
                $display("[TB] FAIL spi_byte: got unexpected byte %02h, required no byte", SPI_W_DATA);
            end else begin
                eb = exp_bytes.pop_front();
                if (!eb[8] && SPI_W_DATA !== eb[7:0]) begin
                    errors++;
                    $display("[TB] FAIL spi_byte: got %02h, required %02h", SPI_W_DATA, eb[7:0]);
                end
            end
            checks++;
            if (SPI_CS_N !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cs_low: SPI_CS_N=%b during strobe, required 0", SPI_CS_N);
            end
        end
    end

    // Response monitor: every RESP_VALID is compared against the queued result
    logic [8:0] er;
    always @(negedge CLK50) begin
        if (RST_N && RESP_VALID) begin
            checks++;
            if (exp_resp.size() == 0) begin
                errors++;
                $display("[TB] FAIL resp: got unexpected RESP_VALID r1=%02h to=%b, required none", RESP_R1, RESP_TIMEOUT);
            end else begin
                er = exp_resp.pop_front();
                if (RESP_R1 !== er[7:0] || RESP_TIMEOUT !== er[8]) begin
                    errors++;
                    $display("[TB] FAIL resp: got r1=%02h to=%b, required r1=%02h to=%b",
                             RESP_R1, RESP_TIMEOUT, er[7:0], er[8]);
                end
            end
            checks++;
            if (CMD_BUSY !== 1'b0 || SPI_CS_N !== 1'b1) begin
                errors++;
                $display("[TB] FAIL resp_idle: got busy=%b cs_n=%b, required busy=0 cs_n=1", CMD_BUSY, SPI_CS_N);
            end
        end
    end

    task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic expectToken(input logic [47:0] tok, input bit crc_dc);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = tok[47 - 8*i -: 8];
            exp_bytes.push_back({(i == 5) ? crc_dc : 1'b0, b});
        end
    endtask

    task automatic expectFill(input int n);
        for (int i = 0; i < n; i++) exp_bytes.push_back({1'b0, 8'hFF});
    endtask

    task automatic expectResp(input logic to, input logic [7:0] r1);
        exp_resp.push_back({to, r1});
    endtask

    // Pulse one command request and confirm it was taken
    task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg);
        @(posedge CLK50); #1;
        CMD_IDX = idx;
        CMD_ARG = arg;
        CMD_STB = 1'b1;
        @(posedge CLK50); #1;
        CMD_STB = 1'b0;
        checkEq("busy_after_accept", {31'd0, CMD_BUSY}, 32'd1);
    endtask

    // Bounded wait for the response pulse; returns on the REPORT cycle
    task automatic checkOutput(input int max_cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge CLK50);
            if (RESP_VALID) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_timeout: no RESP_VALID within %0d cycles, required one", max_cycles);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK50);
    endtask

    initial begin
        RST_N = 1'b0;
        repeat (3) @(posedge CLK50);
        #1;
        checkEq("rst_cs_n",    {31'd0, SPI_CS_N},     32'd1);
        checkEq("rst_w_stb",   {31'd0, SPI_W_STB},    32'd0);
        checkEq("rst_w_data",  {24'd0, SPI_W_DATA},   32'h00);
        checkEq("rst_busy",    {31'd0, CMD_BUSY},     32'd0);
        checkEq("rst_valid",   {31'd0, RESP_VALID},   32'd0);
        checkEq("rst_r1",      {24'd0, RESP_R1},      32'hFF);
        checkEq("rst_timeout", {31'd0, RESP_TIMEOUT}, 32'd0);
        @(negedge CLK50);
        RST_N = 1'b1;
        idle(3);

        // CMD0, replies FF then 01: 40 00 00 00 00 95 FF FF FF
        $display("[TB] CMD0 basic");
        reply_q = {8'hFF, 8'h01};
        expectToken(48'h40_00000000_95, 1'b0);
        expectFill(3);
        expectResp(1'b0, 8'h01);
        applyStimulus(CMD0, 32'h0);
        checkOutput(400);
        idle(30);

        // CMD8 with 0x1AA, R1 on first poll
        $display("[TB] CMD8");
        reply_q = {8'h01};
        expectToken({8'h48, 32'h000001AA, CMD8_CRC}, 1'b0);
        expectFill(2);
        expectResp(1'b0, 8'h01);
        applyStimulus(CMD8, 32'h000001AA);
        checkOutput(400);
        idle(30);

        // No reply at all: 8 polls + trailer, timeout
        $display("[TB] timeout");
        reply_q = {};
        expectToken(48'h40_00000000_95, 1'b0);
        expectFill(9);
        expectResp(1'b1, 8'hFF);
        applyStimulus(CMD0, 32'h0);
        checkOutput(600);
        idle(30);

        // R1 arrives on the last allowed poll
        $display("[TB] R1 on last poll");
        reply_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        expectToken(48'h40_00000000_95, 1'b0);
        expectFill(9);
        expectResp(1'b0, 8'h00);
        applyStimulus(CMD0, 32'h0);
        checkOutput(600);
        idle(30);

        // Non-trivial argument and an error R1
        $display("[TB] CMD17 error R1");
        reply_q = {8'hFF, 8'h05};
        expectToken(48'h51_12345678_95, CRC_DC);
        expectFill(3);
        expectResp(1'b0, 8'h05);
        applyStimulus(CMD17, 32'h12345678);
        checkOutput(400);
        idle(30);

        // Extra request while busy is dropped; next one right after REPORT is taken
        $display("[TB] busy drop and back-to-back");
        reply_q = {8'h01};
        expectToken(48'h40_00000000_95, 1'b0);
        expectFill(2);
        expectResp(1'b0, 8'h01);
        applyStimulus(CMD0, 32'h0);
        repeat (21) @(posedge CLK50);
        #1;
        CMD_IDX = CMD55;
        CMD_ARG = 32'hFFFFFFFF;
        CMD_STB = 1'b1;
        @(posedge CLK50); #1;
        CMD_STB = 1'b0;
        checkOutput(400);
        reply_q = {8'h01};
        expectToken(48'h40_00000000_95, 1'b0);
        expectFill(2);
        expectResp(1'b0, 8'h01);
        @(posedge CLK50); #1;
        CMD_IDX = CMD0;
        CMD_ARG = 32'h0;
        CMD_STB = 1'b1;
        @(posedge CLK50); #1;
        CMD_STB = 1'b0;
        checkEq("busy_b2b", {31'd0, CMD_BUSY}, 32'd1);
        checkOutput(400);
        idle(30);

        // Asynchronous reset while waiting on a poll byte
        $display("[TB] reset during poll");
        reply_q = {};
        expectToken(48'h40_00000000_95, 1'b0);
        expectFill(1);
        applyStimulus(CMD0, 32'h0);
        begin
            bit reached;
            reached = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge CLK50);
                if (tx_idx >= 7) begin
                    reached = 1;
                    break;
                end
            end
            checkEq("reached_poll", {31'd0, reached}, 32'd1);
        end
        idle(3);
        #2;
        RST_N = 1'b0;
        #1;
        checkEq("async_cs_n",  {31'd0, SPI_CS_N},  32'd1);
        checkEq("async_busy",  {31'd0, CMD_BUSY},  32'd0);
        checkEq("async_w_stb", {31'd0, SPI_W_STB}, 32'd0);
        exp_bytes = {};
        exp_resp  = {};
        reply_q   = {};
        idle(3);
        RST_N = 1'b1;
        idle(3);
        reply_q = {8'h01};
        expectToken(48'h40_00000000_95, 1'b0);
        expectFill(2);
        expectResp(1'b0, 8'h01);
        applyStimulus(CMD0, 32'h0);
        checkOutput(400);
        idle(30);

        checkEq("bytes_left", exp_bytes.size(), 32'd0);
        checkEq("resp_left",  exp_resp.size(),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
